// File: rtl/mux4_arb_pkg.sv
// mux4_arb_pkg: shared constants, state type and select mapping for the mux4 arbiter
package mux4_arb_pkg;
  localparam int NUM_REQ = 4;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  function automatic logic [1:0] idx_to_sel(input logic [1:0] idx);
    return idx;
  endfunction
endpackage

// File: rtl/four_to_one.sv
// four_to_one: combinational 4:1 multiplexer selected by {s1,s0}
module four_to_one (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s0,
  input  logic s1,
  output logic y
);
  assign y = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
endmodule

// File: rtl/mux4_rr_pick.sv
// mux4_rr_pick: round-robin search over req starting after last, optionally skipping last
module mux4_rr_pick
  import mux4_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         last,
  input  logic               mask,
  output logic               found,
  output logic [1:0]         idx
);
  logic [1:0] c;
  // scan offsets from farthest to nearest so the nearest set request wins
  always_comb begin
    found = 1'b0;
    idx = last;
    c = last;
    for (int k = 4; k >= 1; k--) begin
      c = last + 2'(k);
      if (req[c] && !(mask && k == 4)) begin
        found = 1'b1;
        idx = c;
      end
    end
  end
endmodule

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin burst arbiter driving the four_to_one select pair
module mux4_rr_arbiter
  import mux4_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s0,
  output logic               s1,
  output logic               busy
);
  localparam int CW = $clog2(HOLD_MAX + 1);
  localparam logic [CW-1:0] HM = CW'(HOLD_MAX);
  arb_state_t state, state_n;
  logic [1:0] last, last_n, idx;
  logic [CW-1:0] cnt, cnt_n;
  logic found;
  // while granted, last is the owner, so masking it yields "any other requester"
  mux4_rr_pick u_pick (
    .req  (req),
    .last (last),
    .mask (state == GRANT),
    .found(found),
    .idx  (idx)
  );
  // next grant: release wins over expiry, lone expiry re-grants the owner
  always_comb begin
    state_n = state;
    last_n = last;
    cnt_n = cnt;
    if (state == IDLE) begin
      if (found) begin
        state_n = GRANT;
        last_n = idx;
        cnt_n = CW'(1);
      end
    end else if (!req[last]) begin
      state_n = found ? GRANT : IDLE;
      last_n = found ? idx : last;
      cnt_n = found ? CW'(1) : '0;
    end else if (cnt < HM) begin
      cnt_n = cnt + CW'(1);
    end else begin
      last_n = found ? idx : last;
      cnt_n = CW'(1);
    end
  end
  // all outputs registered together from the next state so they stay consistent
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last <= 2'd3;
      cnt <= '0;
      gnt <= '0;
      {s1, s0} <= 2'b00;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      last <= last_n;
      cnt <= cnt_n;
      gnt <= (state_n == GRANT) ? (4'b0001 << last_n) : '0;
      {s1, s0} <= (state_n == GRANT) ? idx_to_sel(last_n) : {s1, s0};
      busy <= (state_n == GRANT);
    end
  end
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed scenario bench for the arbiter in front of four_to_one
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic s0, s1, busy, y;
  int total = 0;
  int bad = 0;

  mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .gnt  (gnt),
    .s0   (s0),
    .s1   (s1),
    .busy (busy)
  );

  four_to_one u_mux (
    .i0(1'b1),
    .i1(1'b0),
    .i2(1'b1),
    .i3(1'b0),
    .s0(s0),
    .s1(s1),
    .y (y)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    req = 4'b1111;
    tick();
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
    total++; if ({s1, s0} !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", {s1, s0}); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) begin bad++; $display("FAIL first_gnt got=%b want=0001", gnt); end
    total++; if ({s1, s0} !== 2'b00) begin bad++; $display("FAIL first_sel got=%b want=00", {s1, s0}); end
    total++; if (y !== 1'b1) begin bad++; $display("FAIL first_y got=%b want=1", y); end
  endtask

  task automatic test_burst_rotation;
    logic [3:0] eg;
    logic [1:0] es;
    do_reset();
    req = 4'b0101;
    for (int c = 0; c < 16; c++) begin
      tick();
      eg = ((c / 4) % 2 == 1) ? 4'b0100 : 4'b0001;
      es = ((c / 4) % 2 == 1) ? 2'b10 : 2'b00;
      total++; if (gnt !== eg) begin bad++; $display("FAIL burst_gnt cyc=%0d got=%b want=%b", c, gnt, eg); end
      total++; if ({s1, s0} !== es) begin bad++; $display("FAIL burst_sel cyc=%0d got=%b want=%b", c, {s1, s0}, es); end
      total++; if (y !== 1'b1) begin bad++; $display("FAIL burst_y cyc=%0d got=%b want=1", c, y); end
    end
  endtask

  task automatic test_early_release;
    do_reset();
    req = 4'b0010;
    tick();
    tick();
    total++; if (gnt !== 4'b0010) begin bad++; $display("FAIL early_owner got=%b want=0010", gnt); end
    req = 4'b1000;
    tick();
    total++; if (gnt !== 4'b1000) begin bad++; $display("FAIL early_gnt got=%b want=1000", gnt); end
    total++; if ({s1, s0} !== 2'b11) begin bad++; $display("FAIL early_sel got=%b want=11", {s1, s0}); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL early_busy got=%b want=1", busy); end
    total++; if (y !== 1'b0) begin bad++; $display("FAIL early_y got=%b want=0", y); end
  endtask

  task automatic test_release_idle;
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
    total++; if ({s1, s0} !== 2'b10) begin bad++; $display("FAIL idle_sel_hold got=%b want=10", {s1, s0}); end
  endtask

  task automatic test_lone_expiry;
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL lone_gnt cyc=%0d got=%b want=0100", c, gnt); end
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL lone_busy cyc=%0d got=%b want=1", c, busy); end
      total++; if (int'(dut.cnt) !== (c % 4) + 1) begin bad++; $display("FAIL lone_cnt cyc=%0d got=%0d want=%0d", c, dut.cnt, (c % 4) + 1); end
    end
  endtask

  task automatic test_fairness;
    int ei;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 32; c++) begin
      tick();
      ei = (c / 4) % 4;
      total++; if (gnt !== (4'b0001 << ei)) begin bad++; $display("FAIL fair_gnt cyc=%0d got=%b want=%b", c, gnt, 4'b0001 << ei); end
      total++; if (!$onehot(gnt)) begin bad++; $display("FAIL fair_onehot cyc=%0d got=%b want=onehot", c, gnt); end
      total++; if (int'({s1, s0}) !== ei) begin bad++; $display("FAIL fair_sel cyc=%0d got=%b want=%0d", c, {s1, s0}, ei); end
      total++; if (y !== (ei % 2 == 0)) begin bad++; $display("FAIL fair_y cyc=%0d got=%b want=%b", c, y, ei % 2 == 0); end
    end
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    req = 4'b0100;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mid_pre got=%b want=0100", gnt); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (gnt !== 4'b0000) begin bad++; $display("FAIL mid_gnt got=%b want=0000", gnt); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
    total++; if ({s1, s0} !== 2'b00) begin bad++; $display("FAIL mid_sel got=%b want=00", {s1, s0}); end
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0100) begin bad++; $display("FAIL mid_regrant got=%b want=0100", gnt); end
  endtask

  initial begin
    test_reset();
    test_burst_rotation();
    test_early_release();
    test_release_idle();
    test_lone_expiry();
    test_fairness();
    test_reset_mid_grant();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares one `four_to_one` multiplexer among four requesters. Each requester raises a request line. The arbiter grants one requester at a time, holds the grant for a bounded burst, and drives the mux select pair `s1`/`s0` so that the mux output `y` carries the granted requester's input (`i0`..`i3`). It sits directly in front of the `four_to_one` select port. All arbitration state is registered; the mux itself stays combinational.

## Interface
Parameters:
- `HOLD_MAX`, default 4: maximum consecutive cycles one requester keeps the grant while others wait. Legal range is ≥1.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `req`, input, 4: request lines. Bit n is requester n, which maps to mux input `in`.
- `gnt`, output, 4: one-hot grant, or all zeros when no grant is held. Registered.
- `s0`, output, 1: mux select LSB. Registered.
- `s1`, output, 1: mux select MSB. Registered. `{s1,s0}` equals the index of the granted requester.
- `busy`, output, 1: high whenever a grant is held (`gnt != 0`). Registered.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: exactly one `gnt` bit is high.
- Round-robin pointer `last`: 2-bit index of the most recently granted requester.
  - Search order is `last+1`, `last+2`, `last+3`, `last`, modulo 4.
- Hold counter `cnt`: width `$clog2(HOLD_MAX+1)`. It loads 1 on every new grant and increments each cycle the same grant is held.
- IDLE → GRANT: when `req != 0`. The arbiter picks the first set bit in search order, loads `cnt` = 1, and updates `last`.
- GRANT, owner n, when `req[n]` = 1 and `cnt < HOLD_MAX`: hold the grant and increment `cnt`.
- GRANT, owner n, when `req[n]` = 0 (release):
  - If any other request is set, grant the next one in search order in the same edge. There is no idle bubble.
  - Otherwise go to IDLE.
- GRANT, owner n, when `cnt == HOLD_MAX` and `req[n]` = 1 (expiry):
  - If any other request is set, rotate to the next one in search order.
  - Otherwise re-grant n and reload `cnt` = 1.
- Select outputs:
  - `{s1,s0}` follows the granted index.
  - In IDLE, `{s1,s0}` holds its last value. The mux output is don't-care while `busy` = 0.
- Simultaneous events: release and expiry in the same cycle are treated as release.
- A request that deasserts and reasserts while not granted carries no memory. Arbitration looks only at the current `req`.

## Timing
- Reset values: `gnt` = 4'b0000, `s0` = 0, `s1` = 0, `busy` = 0, state = IDLE, `cnt` = 0, `last` = 3. With `last` = 3, requester 0 has top priority after reset.
- Asserting `rst_n` mid-grant clears all outputs immediately (asynchronous). The first grant is possible at the first rising edge after deassertion.
- Latency: `req` sampled at edge k produces `gnt`/`s1`/`s0` valid after edge k, i.e. one cycle. Then `y` is valid combinationally through the mux in the same cycle.
- Handover: the old grant drops and the new grant rises on the same edge. `gnt` is never two-hot.
- Worst-case wait for a continuously asserting requester: 3 × `HOLD_MAX` cycles plus 1.
- `gnt`, `s0`, `s1` and `busy` all update on the same edge and are mutually consistent every cycle.

## Structure
- Shared package `mux4_arb_pkg`:
  - `NUM_REQ` = 4.
  - State typedef `arb_state_t` {IDLE, GRANT}.
  - Function `idx_to_sel` mapping a 2-bit index to `{s1,s0}`.
- Sub-module `mux4_rr_pick`: combinational priority picker.
  - Inputs: `req[3:0]`, `last[1:0]`, plus a mask bit that excludes the current owner.
  - Outputs: `found` and `idx[1:0]`.
  - The top level instantiates it once for "any other requester" and handles the re-grant case itself.
- The bench instantiates `mux4_rr_arbiter` driving `four_to_one` with `i0..i3` = 1,0,1,0, matching the existing mux bench.

## Test plan
- Reset: hold `rst_n` = 0 with `req` = 4'b1111. Expect `gnt` = 0, `s1s0` = 00, `busy` = 0. Release reset: after the first edge, `gnt` = 0001, `s1s0` = 00, `y` = 1.
- Burst rotation: `HOLD_MAX` = 4, `req` = 4'b0101 held steady. Expect `gnt` = 0001 for 4 cycles, then 0100 for 4 cycles (`s1s0` = 10, `y` = 1), then 0001 again, repeating.
- Early release: owner 1 (`req` = 4'b0010) drops `req[1]` while `req` becomes 4'b1000 on the same cycle. Expect `gnt` = 1000 and `s1s0` = 11 on the next edge, with no IDLE cycle.
- Lone expiry: only `req[2]` high for 10 cycles. Expect `gnt` = 0100 continuously, `cnt` wraps 1..4 repeatedly, `busy` stays 1.
- Full contention fairness: `req` = 4'b1111 for 32 cycles with `HOLD_MAX` = 4. Expect grant order 0,1,2,3,0,1,2,3, each for exactly 4 cycles, and `gnt` one-hot on every cycle.
- Reset mid-grant: assert `rst_n` = 0 between edges while `gnt` = 0100. Expect `gnt` = 0 and `busy` = 0 immediately. After release with `req` = 4'b0100, expect `gnt` = 0100 one edge later.
